// File: rtl/wb_uart_rx.sv
// Wishbone UART receiver: 8N1 serial input, byte FIFO, status flags and interrupt.
// Define WB_UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module wb_uart_rx #(
   parameter int CLK_FREQ_HZ = 24000000,
   parameter int BAUD        = 115200,
   parameter int FIFO_AW     = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   input  logic        uart_rx,
   output logic        irq_o
);

   localparam int             DEPTH     = 1 << FIFO_AW;
   localparam logic [15:0]    DIV_RESET = 16'(CLK_FREQ_HZ / BAUD);
   localparam logic [15:0]    DIV_MIN   = 16'd16;
   localparam logic [FIFO_AW:0]   CNT_ONE = 1;
   localparam logic [FIFO_AW-1:0] PTR_ONE = 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef WB_UART_RX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif
   localparam logic [2:0] ST_STOP   = 3'd4;

   // ---------------- input synchronizer and edge detect ----------------
   logic       rx_meta_reg, rx_sync_reg, rx_prev_reg;
   logic [1:0] settle_reg;
   logic       rx_fall;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
         settle_reg  <= 2'd0;
      end else begin
         rx_meta_reg <= uart_rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
         if (settle_reg != 2'd3) settle_reg <= settle_reg + 2'd1;
      end
   end

   // Ignore edges until the reset values of the flops have flushed, so a line
   // held low across reset release is not mistaken for a start bit.
   assign rx_fall = (settle_reg == 2'd3) && rx_prev_reg && !rx_sync_reg;

   // ---------------- receiver FSM ----------------
   logic [2:0]  state_reg;
   logic [15:0] cnt_reg, frame_div_reg, div_reg;
   logic [2:0]  bit_idx_reg;
   logic [7:0]  shift_reg;
   logic        push_valid_reg, ferr_set_reg;
   logic [7:0]  push_byte_reg;
`ifdef WB_UART_RX_PARITY_EN
   logic        parity_bad_reg, perr_set_reg;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= 16'd0;
         frame_div_reg  <= DIV_RESET;
         bit_idx_reg    <= 3'd0;
         shift_reg      <= 8'd0;
         push_valid_reg <= 1'b0;
         push_byte_reg  <= 8'd0;
         ferr_set_reg   <= 1'b0;
`ifdef WB_UART_RX_PARITY_EN
         parity_bad_reg <= 1'b0;
         perr_set_reg   <= 1'b0;
`endif
      end else begin
         push_valid_reg <= 1'b0;
         ferr_set_reg   <= 1'b0;
`ifdef WB_UART_RX_PARITY_EN
         perr_set_reg   <= 1'b0;
`endif
         case (state_reg)
            ST_IDLE: begin
               if (rx_fall) begin
                  state_reg     <= ST_START;
                  frame_div_reg <= div_reg;
                  cnt_reg       <= (div_reg >> 1) - 16'd1;
               end
            end
            ST_START: begin
               if (cnt_reg != 16'd0) begin
                  cnt_reg <= cnt_reg - 16'd1;
               end else if (!rx_sync_reg) begin
                  state_reg   <= ST_DATA;
                  cnt_reg     <= frame_div_reg - 16'd1;
                  bit_idx_reg <= 3'd0;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (cnt_reg != 16'd0) begin
                  cnt_reg <= cnt_reg - 16'd1;
               end else begin
                  shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                  cnt_reg     <= frame_div_reg - 16'd1;
                  bit_idx_reg <= bit_idx_reg + 3'd1;
                  if (bit_idx_reg == 3'd7) begin
`ifdef WB_UART_RX_PARITY_EN
                     state_reg <= ST_PARITY;
`else
                     state_reg <= ST_STOP;
`endif
                  end
               end
            end
`ifdef WB_UART_RX_PARITY_EN
            ST_PARITY: begin
               if (cnt_reg != 16'd0) begin
                  cnt_reg <= cnt_reg - 16'd1;
               end else begin
                  parity_bad_reg <= ^{shift_reg, rx_sync_reg};
                  perr_set_reg   <= ^{shift_reg, rx_sync_reg};
                  cnt_reg        <= frame_div_reg - 16'd1;
                  state_reg      <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (cnt_reg != 16'd0) begin
                  cnt_reg <= cnt_reg - 16'd1;
               end else begin
                  state_reg <= ST_IDLE;
                  if (!rx_sync_reg) begin
                     ferr_set_reg <= 1'b1;
`ifdef WB_UART_RX_PARITY_EN
                  end else if (!parity_bad_reg) begin
`else
                  end else begin
`endif
                     push_valid_reg <= 1'b1;
                     push_byte_reg  <= shift_reg;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // ---------------- wishbone handshake ----------------
   logic        ack_reg, pop_pend_reg, irq_reg;
   logic [31:0] dat_o_reg, rd_data;
   logic        wb_req, wr_req, rd_req, pop;

   assign wb_req = wb_cyc_i && wb_stb_i && !ack_reg;
   assign wr_req = wb_req && wb_we_i;
   assign rd_req = wb_req && !wb_we_i;
   // The pop is decided at request time so a byte pushed meanwhile is never lost.
   assign pop    = ack_reg && pop_pend_reg;

   // ---------------- FIFO ----------------
   logic [7:0]         mem [0:DEPTH-1];
   logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_AW:0]   count_reg;
   logic               not_empty, full, push_ok, ovr_set;

   assign not_empty = (count_reg != '0);
   assign full      = count_reg[FIFO_AW];
   assign push_ok   = push_valid_reg && (!full || pop);
   assign ovr_set   = push_valid_reg && full && !pop;

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr_reg] <= push_byte_reg;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         if (push_ok && !pop)      count_reg <= count_reg + CNT_ONE;
         else if (!push_ok && pop) count_reg <= count_reg - CNT_ONE;
      end
   end

   // ---------------- status flags and divisor ----------------
   logic ovr_flag, ferr_flag, perr_flag;
   logic status_wr;

   assign status_wr = wr_req && (wb_adr_i == 2'd1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ovr_flag  <= 1'b0;
         ferr_flag <= 1'b0;
         div_reg   <= DIV_RESET;
      end else begin
         ovr_flag  <= ovr_set      || (ovr_flag  && !(status_wr && wb_dat_i[2]));
         ferr_flag <= ferr_set_reg || (ferr_flag && !(status_wr && wb_dat_i[3]));
         if (wr_req && (wb_adr_i == 2'd2))
            div_reg <= (wb_dat_i[15:0] < DIV_MIN) ? DIV_MIN : wb_dat_i[15:0];
      end
   end

`ifdef WB_UART_RX_PARITY_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) perr_flag <= 1'b0;
      else          perr_flag <= perr_set_reg || (perr_flag && !(status_wr && wb_dat_i[4]));
   end
`else
   assign perr_flag = 1'b0;
`endif

   always_comb begin
      rd_data = 32'd0;
      case (wb_adr_i)
         2'd0: if (not_empty) rd_data = {23'd0, 1'b1, mem[rd_ptr_reg]};
         2'd1: rd_data = {16'd0, 8'(count_reg), 3'd0, perr_flag, ferr_flag,
                          ovr_flag, full, not_empty};
         2'd2: rd_data = {16'd0, div_reg};
         default: rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ack_reg      <= 1'b0;
         dat_o_reg    <= 32'd0;
         pop_pend_reg <= 1'b0;
         irq_reg      <= 1'b0;
      end else begin
         ack_reg      <= wb_req;
         dat_o_reg    <= rd_req ? rd_data : 32'd0;
         pop_pend_reg <= rd_req && (wb_adr_i == 2'd0) && not_empty;
         irq_reg      <= not_empty || ovr_flag || ferr_flag || perr_flag;
      end
   end

   assign wb_ack_o = ack_reg;
   assign wb_dat_o = dat_o_reg;
   assign irq_o    = irq_reg;

   logic unused_bits;
   assign unused_bits = &{1'b0, wb_dat_i[31:16]};

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed self-checking bench for wb_uart_rx at default parameters.
// Frames carry an even parity bit when WB_UART_RX_PARITY_EN is defined.
module tb_wb_uart_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  adr = 2'd0;
   logic [31:0] dat_i = 32'd0;
   logic [31:0] dat_o;
   logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
   logic        ack;
   logic        rx = 1'b1;
   logic        irq;

   int errors = 0;
   int checks = 0;
   logic [31:0] rd;

   wb_uart_rx dut (
      .clock    (clk),
      .reset_n  (rst_n),
      .wb_adr_i (adr),
      .wb_dat_i (dat_i),
      .wb_dat_o (dat_o),
      .wb_we_i  (we),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_ack_o (ack),
      .uart_rx  (rx),
      .irq_o    (irq)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One wishbone access; also checks one-cycle ack latency and ack width.
   task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] wd,
                          output logic [31:0] rdat);
      int n;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = wd;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!ack && n < 8);
      rdat = dat_o;
      chk("ack_latency", 32'(n), 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_i = 32'd0;
      tick(1);
      chk("ack_width", {31'd0, ack}, 32'd0);
      $display("wb %s adr=%0d wdata=0x%08h rdata=0x%08h", w ? "wr" : "rd", a, wd, rdat);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
      rx = 1'b0;
      tick(div);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(div);
      end
`ifdef WB_UART_RX_PARITY_EN
      rx = ^b;
      tick(div);
`endif
      rx = stop_bit;
      tick(div);
      rx = 1'b1;
      tick(div);
      $display("uart sent byte=0x%02h stop=%0d div=%0d", b, stop_bit, div);
   endtask

   initial begin
      // reset state
      tick(3);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      rst_n = 1'b1;
      tick(5);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("rst_status", rd, 32'h0);
      wb_xfer(1'b0, 2'd2, 32'd0, rd);  chk("rst_divisor", rd, 32'd208);
      wb_xfer(1'b0, 2'd0, 32'd0, rd);  chk("empty_rxdata", rd, 32'h0);

      // single byte
      send_frame(8'h55, 1'b1, 208);
      tick(10);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("one_status", rd, 32'h0000_0101);
      chk("one_irq", {31'd0, irq}, 32'd1);
      wb_xfer(1'b0, 2'd0, 32'd0, rd);  chk("one_rxdata", rd, 32'h155);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("one_status_after", rd, 32'h0);
      tick(2);
      chk("one_irq_after", {31'd0, irq}, 32'd0);

      // overflow: 17 bytes into a 16-entry FIFO
      for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 208);
      tick(10);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("ovr_status", rd, 32'h0000_1007);
      for (int i = 0; i < 16; i++) begin
         wb_xfer(1'b0, 2'd0, 32'd0, rd);
         chk("ovr_read", rd, 32'h100 + 32'(i));
      end
      wb_xfer(1'b0, 2'd0, 32'd0, rd);  chk("ovr_read17", rd, 32'h0);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("ovr_sticky", rd, 32'h4);
      wb_xfer(1'b1, 2'd1, 32'h4, rd);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("ovr_cleared", rd, 32'h0);

      // framing error
      send_frame(8'hA3, 1'b0, 208);
      tick(10);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("ferr_status", rd, 32'h8);
      chk("ferr_irq", {31'd0, irq}, 32'd1);
      wb_xfer(1'b1, 2'd1, 32'h8, rd);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("ferr_cleared", rd, 32'h0);
      tick(2);
      chk("ferr_irq_clr", {31'd0, irq}, 32'd0);

      // start-bit glitch
      rx = 1'b0;
      tick(50);
      rx = 1'b1;
      tick(400);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("glitch_status", rd, 32'h0);
      chk("glitch_irq", {31'd0, irq}, 32'd0);

      // reserved address
      wb_xfer(1'b1, 2'd3, 32'hFFFF_FFFF, rd);
      wb_xfer(1'b0, 2'd3, 32'd0, rd);  chk("adr3_read", rd, 32'h0);
      wb_xfer(1'b0, 2'd2, 32'd0, rd);  chk("adr3_div_kept", rd, 32'd208);

      // divisor programming and clamping
      wb_xfer(1'b1, 2'd2, 32'd300, rd);
      wb_xfer(1'b0, 2'd2, 32'd0, rd);  chk("div_300", rd, 32'd300);
      wb_xfer(1'b1, 2'd2, 32'd5, rd);
      wb_xfer(1'b0, 2'd2, 32'd0, rd);  chk("div_clamp", rd, 32'd16);
      send_frame(8'h3C, 1'b1, 16);
      tick(10);
      wb_xfer(1'b0, 2'd0, 32'd0, rd);  chk("div16_rxdata", rd, 32'h13C);

      // reset during bit 4 of a 0x00 frame at divisor 16
      rx = 1'b0;
      tick(16 * 5 + 8);
      rst_n = 1'b0;
      #2;
      chk("midrst_ack", {31'd0, ack}, 32'd0);
      chk("midrst_dat", dat_o, 32'd0);
      chk("midrst_irq", {31'd0, irq}, 32'd0);
      tick(3);
      rst_n = 1'b1;
      tick(16 * 3 + 8);
      rx = 1'b1;
      tick(400);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("midrst_status", rd, 32'h0);
      wb_xfer(1'b0, 2'd2, 32'd0, rd);  chk("midrst_divisor", rd, 32'd208);
      send_frame(8'h81, 1'b1, 208);
      tick(10);
      wb_xfer(1'b0, 2'd0, 32'd0, rd);  chk("midrst_rxdata", rd, 32'h181);
      wb_xfer(1'b0, 2'd1, 32'd0, rd);  chk("final_status", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_uart_rx.md
WB_UART_RX -- requirements
Module: wb_uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 24000000, wishbone clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, reset baud rate; reset divisor = CLK_FREQ_HZ/BAUD, integer truncated (208 at defaults).
REQ-003 SHALL have parameter FIFO_AW, default 4, receive FIFO depth = 2^FIFO_AW bytes.
REQ-004 SHALL have ports:
- clock  in  1  wishbone clock
- reset_n  in  1  asynchronous active-low reset
- wb_adr_i  in  2  word address (0 RXDATA, 1 STATUS, 2 DIVISOR, 3 reserved)
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  acknowledge
- uart_rx  in  1  serial input, idle high, asynchronous
- irq_o  out  1  interrupt request

Function
REQ-005 uart_rx SHALL pass through a 2-flop synchronizer (flops reset to 1) before any use.
REQ-006 Receiver FSM states SHALL be IDLE, START, DATA, (PARITY), STOP.
REQ-007 IDLE -> START on a synchronized 1->0 edge; the active divisor SHALL be latched at this transition.
REQ-008 START: after divisor/2 clocks, line low -> DATA; line high -> IDLE (glitch rejected, nothing flagged).
REQ-009 DATA: 8 bits, LSB first, each sampled divisor clocks after the previous sample; then -> STOP (or PARITY).
REQ-010 STOP: sample after divisor clocks; high -> push byte; low -> set sticky FERR, discard byte; either way -> IDLE.
REQ-011 Push into a full FIFO SHALL drop the byte and set sticky OVR, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-012 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged; pointers SHALL wrap modulo 2^FIFO_AW.
REQ-013 Wishbone: wb_ack_o SHALL assert one clock after cyc&stb&!ack, for exactly one clock; wb_dat_o SHALL be valid while wb_ack_o is high.
REQ-014 RXDATA read SHALL return {23'b0, not_empty, head_byte}; it SHALL pop one entry in the ack cycle only when not empty; an empty read returns 0 with no side effect; writes are ignored.
REQ-015 STATUS read SHALL return bit0 not_empty, bit1 full, bit2 OVR, bit3 FERR, bit4 PERR, bits[15:8] FIFO count, others 0; writing 1 to bits 2..4 SHALL clear them; a clear and a set in the same cycle SHALL leave the bit set.
REQ-016 DIVISOR is 16 bits R/W; writes below 16 SHALL store 16; a new value SHALL affect only frames whose start is detected afterwards.
REQ-017 Address 3 SHALL read 0 and ignore writes, but still ack.
REQ-018 irq_o SHALL be registered: not_empty | OVR | FERR | PERR.

Reset
REQ-019 reset_n low SHALL asynchronously force: FSM IDLE, FIFO empty, OVR/FERR/PERR 0, divisor to reset value, wb_ack_o 0, wb_dat_o 0, irq_o 0, synchronizer flops 1.
REQ-020 A reset mid-frame SHALL discard the partial byte; after release, reception SHALL restart only on a fresh 1->0 edge.

Configuration
REQ-021 With macro WB_UART_RX_PARITY_EN defined, frames SHALL be 8E1: the PARITY state samples one even-parity bit after bit 7; a mismatch sets sticky PERR and the byte is discarded even if the stop bit is valid.
REQ-022 Without WB_UART_RX_PARITY_EN, frames SHALL be 8N1, the PARITY state SHALL not exist, and STATUS bit4 SHALL read 0.

Verification
REQ-023 Send 0x55 at divisor 208 -> STATUS=0x0000_0101, irq_o=1; RXDATA read returns 0x155; next STATUS=0, irq_o=0.
REQ-024 Send 17 bytes 0x00..0x10 at FIFO_AW=4 with no reads -> STATUS bit1=1, bit2=1, count=16; 16 reads return 0x100..0x10F; the 17th read returns 0.
REQ-025 Send 0xA3 with stop bit low -> FERR=1, FIFO empty; write STATUS 0x8 -> FERR=0, irq_o=0.
REQ-026 Drive uart_rx low for 50 clocks at divisor 208 -> FSM returns to IDLE, no push, no flags.
REQ-027 Write DIVISOR=5 -> reads back 16; send 0x3C at 16 clocks/bit -> RXDATA returns 0x13C.
REQ-028 Assert reset_n low during bit 4 of a frame -> all outputs at reset values; the next full frame 0x81 is received correctly.
